// File: rtl/user_irq_pkg.sv
// Shared constants and helpers for the user interrupt router.
package user_irq_pkg;

   localparam int ROUTE_W = 2;

   localparam logic [31:0] OFF_RAW        = 32'h0000_0000;
   localparam logic [31:0] OFF_PENDING    = 32'h0000_0004;
   localparam logic [31:0] OFF_ENABLE     = 32'h0000_0008;
   localparam logic [31:0] OFF_MODE       = 32'h0000_000C;
   localparam logic [31:0] OFF_ROUTE      = 32'h0000_0010;
   localparam logic [31:0] OFF_IRQ_STATUS = 32'h0000_0014;
   localparam logic [31:0] OFF_FORCE      = 32'h0000_0018;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_EDGE  = 1'b1;

   // Replace the byte lanes of old_v selected by sel with the matching lanes of new_v.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/user_irq_router_if.sv
// Wishbone slave signal bundle for the interrupt router.
interface user_irq_router_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/user_irq_src.sv
// One interrupt source: synchroniser, edge history and the PENDING bit.
module user_irq_src
   import user_irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic src,
   input  logic mode,
   input  logic w1c,
   input  logic force_set,
   output logic level,
   output logic pending
);

   logic s;
   logic s_prev;
   logic mode_prev;
   logic pending_q;
   logic rise;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = src;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         // Shift the raw source through the synchroniser chain.
         always_ff @(posedge clk_sys) begin
            if (!rst_b) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= src;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign rise = s & ~s_prev;

   // Edge history plus PENDING; a level-to-edge switch clears PENDING and
   // swallows any edge in that cycle, and an edge beats a same-cycle W1C.
   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         s_prev    <= 1'b0;
         mode_prev <= MODE_LEVEL;
         pending_q <= 1'b0;
      end else begin
         s_prev    <= s;
         mode_prev <= mode;
         if (mode == MODE_LEVEL)           pending_q <= s;
         else if (mode_prev == MODE_LEVEL) pending_q <= 1'b0;
         else if (rise || force_set)       pending_q <= 1'b1;
         else if (w1c)                     pending_q <= 1'b0;
      end
   end

   assign level   = s;
   assign pending = pending_q;

endmodule

// File: rtl/user_irq_router.sv
// Interrupt aggregator: Wishbone register file, per-source qualification
// and routing of masked pending sources onto the user irq lines.
module user_irq_router
   import user_irq_pkg::*;
#(
   parameter int          N_SRC       = 8,
   parameter int          N_IRQ       = 3,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADR    = 32'h3000_0100,
   parameter logic [31:0] ADR_MASK    = 32'hFFFF_FF00
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   user_irq_router_if.slave wb,
   input  logic [N_SRC-1:0] src_i,
   output logic [N_IRQ-1:0] irq_o
);

   localparam int RW = ROUTE_W * N_SRC;

   logic [N_SRC-1:0] enable_q;
   logic [N_SRC-1:0] mode_q;
   logic [RW-1:0]    route_q;
   logic [N_SRC-1:0] raw_v;
   logic [N_SRC-1:0] pend_v;
   logic [N_SRC-1:0] w1c_v;
   logic [N_SRC-1:0] force_v;
   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] irq_d;
   logic             ack_q;
   logic [31:0]      dat_q;
   logic             match;
   logic             sel_acc;
   logic             wr_en;
   logic [31:0]      off;
   logic [31:0]      lane_dat;
   logic [31:0]      rdata;

   // A fresh access is only taken while ack is low, giving one-cycle acks.
   assign match    = ((wb.wb_adr_i & ADR_MASK) == BASE_ADR);
   assign sel_acc  = wb.wb_cyc_i & wb.wb_stb_i & match & ~ack_q;
   assign wr_en    = sel_acc & wb.wb_we_i;
   assign off      = wb.wb_adr_i & ~ADR_MASK & 32'hFFFF_FFFC;
   assign lane_dat = byte_merge(32'h0, wb.wb_dat_i, wb.wb_sel_i);

   // Strobes into the sources for PENDING clear and FORCE writes.
   always_comb begin
      w1c_v   = '0;
      force_v = '0;
      if (wr_en && off == OFF_PENDING) w1c_v   = N_SRC'(lane_dat);
      if (wr_en && off == OFF_FORCE)   force_v = N_SRC'(lane_dat);
   end

   generate
      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         user_irq_src #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_src (
            .clk_sys  (wb_clk_i),
            .rst_b    (wb_rst_i),
            .src      (src_i[i]),
            .mode     (mode_q[i]),
            .w1c      (w1c_v[i]),
            .force_set(force_v[i]),
            .level    (raw_v[i]),
            .pending  (pend_v[i])
         );
      end
   endgenerate

   // Read mux; unmapped offsets in the window read 0.
   always_comb begin
      rdata = '0;
      case (off)
         OFF_RAW:        rdata = 32'(raw_v);
         OFF_PENDING:    rdata = 32'(pend_v);
         OFF_ENABLE:     rdata = 32'(enable_q);
         OFF_MODE:       rdata = 32'(mode_q);
         OFF_ROUTE:      rdata = 32'(route_q);
         OFF_IRQ_STATUS: rdata = 32'(irq_q);
         default:        rdata = '0;
      endcase
   end

   // Configuration registers, byte-lane writes committed with the ack edge.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         enable_q <= '0;
         mode_q   <= '0;
         route_q  <= '0;
      end else if (wr_en) begin
         case (off)
            OFF_ENABLE: enable_q <= N_SRC'(byte_merge(32'(enable_q), wb.wb_dat_i, wb.wb_sel_i));
            OFF_MODE:   mode_q   <= N_SRC'(byte_merge(32'(mode_q), wb.wb_dat_i, wb.wb_sel_i));
            OFF_ROUTE:  route_q  <= RW'(byte_merge(32'(route_q), wb.wb_dat_i, wb.wb_sel_i));
            default:    ;
         endcase
      end
   end

   // Registered ack and read data; data is zero whenever ack is low.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= sel_acc;
         dat_q <= sel_acc ? rdata : 32'h0;
      end
   end

   // OR each enabled pending source into its routed line; out-of-range routes hit nothing.
   always_comb begin
      irq_d = '0;
      for (int i = 0; i < N_SRC; i++) begin
         for (int k = 0; k < N_IRQ; k++) begin
            if (pend_v[i] && enable_q[i] && route_q[ROUTE_W*i +: ROUTE_W] == ROUTE_W'(k))
               irq_d[k] = 1'b1;
         end
      end
   end

   // Output register.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) irq_q <= '0;
      else           irq_q <= irq_d;
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_irq_router.sv
// Bench for user_irq_router with default parameters (8 sources, 3 irqs, 2 sync stages).
module tb_user_irq_router;
   import user_irq_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0100;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic [7:0] src = '0;
   logic [2:0] irq;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [31:0] off;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[12];

   user_irq_router_if bus();

   user_irq_router dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst_b),
      .wb      (bus),
      .src_i   (src),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_irq(input string name, input logic [2:0] exp);
      chk(name, {29'b0, irq}, {29'b0, exp});
   endtask

   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, output logic got, output logic [31:0] rd);
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
      bus.wb_we_i  = we;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      got = 1'b0;
      rd  = '0;
      for (int c = 0; c < 8 && !got; c++) begin
         tick();
         if (bus.wb_ack_o) begin
            got = 1'b1;
            rd  = bus.wb_dat_o;
         end
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
      logic        got;
      logic [31:0] rd;
      wb_access(BASE + off, 1'b1, dat, sel, got, rd);
      chk($sformatf("wr_ack_%02h", off[7:0]), {31'b0, got}, 32'h1);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
      logic        got;
      logic [31:0] rd;
      exp_t        e;
      sb_q.push_back('{name, exp});
      wb_access(BASE + off, 1'b0, 32'h0, 4'hF, got, rd);
      e = sb_q.pop_front();
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: no ack, expected data 0x%08h", e.name, e.exp);
      end else begin
         chk(e.name, rd, e.exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        got;
      logic [31:0] rd;

      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;

      vecs[0]  = '{OFF_ENABLE,     32'hFFFF_FFFF, 4'b0001, 32'h0000_00FF};
      vecs[1]  = '{OFF_ENABLE,     32'h0000_A55A, 4'b1111, 32'h0000_005A};
      vecs[2]  = '{OFF_ENABLE,     32'hFFFF_FF00, 4'b0010, 32'h0000_005A};
      vecs[3]  = '{OFF_MODE,       32'h0000_00C3, 4'b1111, 32'h0000_00C3};
      vecs[4]  = '{OFF_MODE,       32'hFFFF_FF00, 4'b0001, 32'h0000_0000};
      vecs[5]  = '{OFF_ROUTE,      32'h1234_5678, 4'b1111, 32'h0000_5678};
      vecs[6]  = '{OFF_ROUTE,      32'hFFFF_AB00, 4'b0010, 32'h0000_AB78};
      vecs[7]  = '{OFF_RAW,        32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
      vecs[8]  = '{OFF_IRQ_STATUS, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
      vecs[9]  = '{OFF_FORCE,      32'h0000_00FF, 4'b1111, 32'h0000_0000};
      vecs[10] = '{32'h0000_0040,  32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
      vecs[11] = '{OFF_PENDING,    32'h0000_00FF, 4'b1111, 32'h0000_0000};

      // reset and idle behaviour
      repeat (3) tick();
      rst_b = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("idle_ack", {31'b0, bus.wb_ack_o}, 32'h0);
         chk_irq("idle_irq", 3'b000);
      end
      for (int r = 0; r < 7; r++) rd_chk($sformatf("rst_reg_%02h", 4*r), 32'(4*r), 32'h0);

      // register write/readback table
      for (int v = 0; v < 12; v++) begin
         wr(vecs[v].off, vecs[v].wdat, vecs[v].sel);
         rd_chk($sformatf("vec%0d", v), vecs[v].off, vecs[v].exp);
      end
      wr(OFF_ENABLE, 32'h0);
      wr(OFF_ROUTE, 32'h0);
      wr(OFF_MODE, 32'h0);
      rd_chk("pend_clean", OFF_PENDING, 32'h0);

      // edge source 0 on irq 0, latency and W1C
      wr(OFF_MODE, 32'h01);
      wr(OFF_ENABLE, 32'h01);
      src[0] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) src[0] = 1'b0;
         chk_irq($sformatf("edge0_c%0d", c), (c >= 4) ? 3'b001 : 3'b000);
      end
      rd_chk("edge0_pend", OFF_PENDING, 32'h01);
      rd_chk("edge0_stat", OFF_IRQ_STATUS, 32'h01);
      wr(OFF_PENDING, 32'h01);
      chk_irq("w1c0_at_ack", 3'b001);
      tick();
      chk_irq("w1c0_after", 3'b000);
      rd_chk("w1c0_pend", OFF_PENDING, 32'h0);

      // level source 3 on irq 2
      wr(OFF_MODE, 32'h00);
      wr(OFF_ROUTE, 32'h80);
      wr(OFF_ENABLE, 32'h08);
      src[3] = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 10) src[3] = 1'b0;
         chk_irq($sformatf("lvl3_c%0d", c), (c >= 4 && c <= 13) ? 3'b100 : 3'b000);
      end
      src[3] = 1'b1;
      repeat (6) tick();
      wr(OFF_PENDING, 32'h08);
      rd_chk("lvl3_w1c_pend", OFF_PENDING, 32'h08);
      chk_irq("lvl3_w1c_irq", 3'b100);
      src[3] = 1'b0;
      repeat (6) tick();
      chk_irq("lvl3_drop", 3'b000);

      // masked edge on source 5, then unmask, then route out of range
      wr(OFF_ENABLE, 32'h00);
      wr(OFF_ROUTE, 32'h400);
      wr(OFF_MODE, 32'h20);
      src[5] = 1'b1;
      tick();
      src[5] = 1'b0;
      repeat (5) tick();
      rd_chk("mask5_pend", OFF_PENDING, 32'h20);
      chk_irq("mask5_irq", 3'b000);
      wr(OFF_ENABLE, 32'h20);
      chk_irq("unmask5_at_ack", 3'b000);
      tick();
      chk_irq("unmask5_irq", 3'b010);
      wr(OFF_ROUTE, 32'hC00);
      tick();
      chk_irq("route5_none", 3'b000);
      rd_chk("route5_pend", OFF_PENDING, 32'h20);

      // edge/W1C collision, FORCE and mode switches on source 1
      wr(OFF_MODE, 32'h02);
      wr(OFF_ENABLE, 32'h02);
      wr(OFF_ROUTE, 32'h0);
      rd_chk("coll_pre", OFF_PENDING, 32'h0);
      src[1] = 1'b1;
      tick();
      tick();
      wr(OFF_PENDING, 32'h02);
      src[1] = 1'b0;
      rd_chk("coll_set_wins", OFF_PENDING, 32'h02);
      wr(OFF_FORCE, 32'h02);
      rd_chk("force_pending", OFF_PENDING, 32'h02);
      wr(OFF_PENDING, 32'h02);
      rd_chk("w1c1", OFF_PENDING, 32'h0);
      wr(OFF_FORCE, 32'h02);
      rd_chk("force1", OFF_PENDING, 32'h02);
      tick();
      chk_irq("force1_irq", 3'b001);
      wr(OFF_FORCE, 32'h10);
      rd_chk("force_level", OFF_PENDING, 32'h02);
      wr(OFF_MODE, 32'h00);
      tick();
      rd_chk("edge_to_level", OFF_PENDING, 32'h0);

      // decode window, unselected address, reset mid-transaction
      rd_chk("hole_40", 32'h40, 32'h0);
      wb_access(32'h3000_0200, 1'b0, 32'h0, 4'hF, got, rd);
      chk("unsel_no_ack", {31'b0, got}, 32'h0);
      wr(OFF_ENABLE, 32'h33);
      rd_chk("en33", OFF_ENABLE, 32'h33);
      bus.wb_adr_i = BASE + OFF_ENABLE;
      bus.wb_we_i  = 1'b0;
      bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      rst_b = 1'b0;
      tick();
      chk("rst_mid_ack", {31'b0, bus.wb_ack_o}, 32'h0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      rst_b = 1'b1;
      tick();
      chk("rst_mid_ack2", {31'b0, bus.wb_ack_o}, 32'h0);
      rd_chk("rst_mid_en", OFF_ENABLE, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/user_irq_router.md
Name: user_irq_router

Overview:
- Parametrised interrupt aggregator. Replaces the fixed one-to-one wiring of accelerator and UART interrupts onto user_irq.
- Takes N_SRC interrupt sources from user-area blocks. Each source is independently synchronised, edge- or level-qualified, masked and routed to one of N_IRQ user_irq outputs.
- Configured and inspected through a Wishbone slave sharing the management bus alongside the sudoku accelerator.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16).
- N_IRQ, 3, number of irq outputs (1..4).
- SYNC_STAGES, 2, synchroniser flops per source (0..3); 0 means the source is already in the wb_clk_i domain.
- BASE_ADR, 32'h3000_0100, Wishbone base address.
- ADR_MASK, 32'hFFFF_FF00, decode mask; the block is selected when (wb_adr_i & ADR_MASK) == BASE_ADR.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- wb_adr_i  in  32  Wishbone address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- src_i  in  N_SRC  raw interrupt sources.
- irq_o  out  N_IRQ  routed interrupts, to user_irq.

Behaviour:
- Reset (wb_rst_i low at a clock edge) clears ENABLE, MODE, ROUTE, PENDING, synchroniser and edge-history flops, irq_o, wb_ack_o and wb_dat_o to 0.
- Reset mid-transaction drops the transaction; no ack is issued.
- Register map, word offsets; bits at and above N_SRC read 0 and ignore writes:
  - 0x00 RAW (RO): synchronised source levels.
  - 0x04 PENDING: RO in level mode. In edge mode, writing 1 clears the bit (W1C).
  - 0x08 ENABLE (RW): per-source mask.
  - 0x0C MODE (RW): 1 = rising-edge, 0 = level.
  - 0x10 ROUTE (RW): bits [2i+1:2i] select the irq index for source i. A route value >= N_IRQ routes the source nowhere.
  - 0x14 IRQ_STATUS (RO): current irq_o.
  - 0x18 FORCE (WO, reads 0): writing 1 sets PENDING for edge-mode sources; ignored for level-mode sources.
  - Other offsets inside the decode window: acked, read 0, writes ignored.
- Wishbone:
  - Selected access = cyc & stb & address match.
  - wb_ack_o is registered: it asserts the cycle after a selected access is seen with ack low, and stays high for exactly one cycle. Back-to-back strobes therefore ack every other cycle.
  - wb_dat_o is valid while ack is high and 0 otherwise.
  - Writes honour wb_sel_i byte lanes and commit on the same edge that raises ack.
  - An unselected address is never acked.
- Source path, per source i:
  - s = src_i[i] after SYNC_STAGES flops.
  - Level mode: PENDING[i] = registered s.
  - Edge mode: PENDING[i] sets on s & ~s_prev and holds until W1C.
  - Same-cycle set and W1C: set wins.
  - FORCE and W1C on the same bit in different writes: last write wins.
  - Changing MODE from edge to level replaces PENDING with the level on the next edge.
  - Changing MODE from level to edge clears PENDING[i] and loads s_prev with the current s, so no spurious edge is seen.
- Output:
  - irq_o[k] is registered as OR over i of (PENDING[i] & ENABLE[i] & ROUTE[i] == k).
  - Latency from src_i rising to irq_o high is SYNC_STAGES+2 clocks.
  - Clearing ENABLE or PENDING drops irq_o on the following clock edge.
  - ENABLE does not gate PENDING capture. An edge arriving while masked stays pending and fires when unmasked.

Decomposition:
- Package user_irq_pkg holds:
  - register offset constants (RAW, PENDING, ENABLE, MODE, ROUTE, IRQ_STATUS, FORCE);
  - ROUTE_W = 2;
  - mode encoding constants.
- Sub-module user_irq_src: one per source, generated N_SRC times. It contains the synchroniser, edge history and PENDING bit, with mode, w1c, force and level/pending outputs.
- The Wishbone decode, registers and OR-reduction routing stay in the top module.

Test Plan:
- Reset, then read all registers → all read 0. irq_o = 0; wb_ack_o never high without stb.
- ENABLE=0x01, MODE=0x01, ROUTE=0. Pulse src_i[0] high for 1 clock → irq_o[0]=1 exactly 4 clocks later and held. W1C 0x01 to PENDING → irq_o[0]=0 one clock after the ack.
- Level mode on source 3, ROUTE[7:6]=2'b10, ENABLE=0x08. Hold src_i[3] high for 10 clocks → irq_o[2] high for 10 clocks, delayed 4. W1C to PENDING has no effect.
- Edge source 5 with ENABLE=0. Pulse src_i[5] → PENDING=0x20, irq_o=0. Set ENABLE=0x20 → irq_o[ROUTE5] rises on the next clock. ROUTE5=3 with N_IRQ=3 → no irq.
- Edge rise on src_i[1] in the same cycle as a W1C of bit 1 → PENDING[1] stays 1. FORCE=0x02 on an already-pending bit → stays 1. FORCE on a level-mode source → no change.
- Access to BASE_ADR+0x40 → ack with 0. Access to an address outside the mask → no ack within 8 clocks. Write 0xFFFF_FFFF to ENABLE with wb_sel_i=4'b0001 → ENABLE=0xFF. Assert reset mid-transaction → no ack.
